// File: rtl/processor.sv
// processor: single-cycle datapath slice with register bank, add/sub ALU,
// data memory and predicated write-back driven by an upstream decoded control word.
module processor #(
    parameter int WIDTH = 5,
    parameter int NREGS = 32,
    parameter int NMEM  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_sum,
    input  logic             wb,
    input  logic             mem_wb,
    input  logic             imm_wb,
    input  logic             eq_in,
    input  logic             lt_in,
    input  logic             reset_st,
    input  logic             set_st,
    input  logic [4:0]       dest,
    input  logic [4:0]       source1,
    input  logic [4:0]       source2,
    output logic [WIDTH-1:0] target
);
    logic [WIDTH-1:0] bank [NREGS];
    logic [WIDTH-1:0] mem  [NMEM];
    logic             eq_flag, lt_flag;
    logic [WIDTH-1:0] a, b, alu, wdata;
    logic [4:0]       addr;
    logic             exec;

    assign a     = bank[source1];
    assign b     = bank[source2];
    assign addr  = 5'(a);
    assign alu   = alu_sum ? a + b : a - b;
    assign exec  = (!eq_in && !lt_in) || (eq_in && eq_flag) || (lt_in && lt_flag);
    assign wdata = imm_wb ? WIDTH'(source2) : mem_wb ? mem[addr] : alu;

    // memory comes out of reset holding its own address as a known pattern
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) bank[i] <= '0;
            for (int i = 0; i < NMEM; i++) mem[i] <= WIDTH'(i);
            target  <= '0;
            eq_flag <= 1'b0;
            lt_flag <= 1'b0;
        end else begin
            if (wb && exec) begin
                bank[dest] <= wdata;
                target     <= wdata;
            end
            if (mem_wb && !wb && exec) mem[addr] <= b;
            if (reset_st) begin
                eq_flag <= 1'b0;
                lt_flag <= 1'b0;
            end else if (set_st) begin
                eq_flag <= a == b;
                lt_flag <= a < b;
            end
        end
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor: randomized and directed stimulus against an arithmetic reference
// model; expectations are queued per operation and checked by an independent monitor.
module tb_processor;
    logic       clk = 0, reset = 1;
    logic       alu_sum = 0, wb = 0, mem_wb = 0, imm_wb = 0, eq_in = 0, lt_in = 0, reset_st = 0, set_st = 0;
    logic [4:0] dest = 0, source1 = 0, source2 = 0;
    logic [4:0] target;

    processor dut (
        .clk(clk), .reset(reset), .alu_sum(alu_sum), .wb(wb), .mem_wb(mem_wb),
        .imm_wb(imm_wb), .eq_in(eq_in), .lt_in(lt_in), .reset_st(reset_st),
        .set_st(set_st), .dest(dest), .source1(source1), .source2(source2),
        .target(target)
    );

    always #5 clk = ~clk;

    typedef struct {int tgt; int idx; int val; int eqf; int ltf;} exp_t;
    exp_t q[$];
    int mb[32], mm[32];
    int eqf, ltf, tgt;
    int passed = 0, total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mb[i] = 0;
            mm[i] = i;
        end
        eqf = 0; ltf = 0; tgt = 0;
    endtask

    task automatic op(input bit as, input bit w, input bit mw, input bit iw, input bit eqi,
                      input bit lti, input bit rs, input bit ss, input int d, input int s1, input int s2);
        int a, b, data;
        bit ex;
        @(negedge clk);
        alu_sum = as; wb = w; mem_wb = mw; imm_wb = iw; eq_in = eqi; lt_in = lti;
        reset_st = rs; set_st = ss; dest = 5'(d); source1 = 5'(s1); source2 = 5'(s2);
        a = mb[s1]; b = mb[s2];
        ex = (!eqi && !lti) || (eqi && eqf == 1) || (lti && ltf == 1);
        if (iw) data = s2;
        else if (mw) data = mm[a];
        else if (as) data = (a + b) % 32;
        else data = (a + 32 - b) % 32;
        if (w && ex) begin
            mb[d] = data;
            tgt = data;
        end
        if (mw && !w && ex) mm[a] = b;
        if (rs) begin
            eqf = 0; ltf = 0;
        end else if (ss) begin
            eqf = int'(a == b); ltf = int'(a < b);
        end
        q.push_back('{tgt, d, mb[d], eqf, ltf});
    endtask

    task automatic imm(input int d, input int v);
        op(0, 1, 0, 1, 0, 0, 0, 0, d, 0, v);
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_target", int'(target), e.tgt);
                chk($sformatf("sb_bank%0d", e.idx), int'(dut.bank[e.idx]), e.val);
                chk("sb_eq_flag", int'(dut.eq_flag), e.eqf);
                chk("sb_lt_flag", int'(dut.lt_flag), e.ltf);
            end
        end
    end

    initial begin : stim
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        repeat (3) idle();
        settle();
        chk("rst_target", int'(target), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_bank%0d", i), int'(dut.bank[i]), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_mem%0d", i), int'(dut.mem[i]), i);

        imm(1, 0); settle();
        chk("imm_zero_bank1", int'(dut.bank[1]), 0);
        chk("imm_zero_target", int'(target), 0);
        chk("imm_bank0_kept", int'(dut.bank[0]), 0);
        imm(2, 7); settle();
        chk("imm7_bank2", int'(dut.bank[2]), 7);
        chk("imm7_target", int'(target), 7);
        imm(1, 3);
        op(1, 1, 0, 0, 0, 0, 0, 0, 3, 2, 1); settle();
        chk("add_bank3", int'(dut.bank[3]), 10);
        chk("add_target", int'(target), 10);
        op(0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 2); settle();
        chk("sub_wrap_bank4", int'(dut.bank[4]), 28);
        chk("sub_wrap_target", int'(target), 28);
        imm(5, 5);
        op(0, 1, 1, 0, 0, 0, 0, 0, 6, 5, 0); settle();
        chk("load_bank6", int'(dut.bank[6]), 5);
        imm(7, 9);
        op(0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 7);
        op(0, 1, 1, 0, 0, 0, 0, 0, 8, 5, 0); settle();
        chk("store_mem5", int'(dut.mem[5]), 9);
        chk("store_load_bank8", int'(dut.bank[8]), 9);
        imm(9, 4); imm(12, 4);
        op(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 12); settle();
        chk("set_eq", int'(dut.eq_flag), 1);
        chk("set_lt", int'(dut.lt_flag), 0);
        op(0, 1, 0, 1, 1, 0, 0, 0, 10, 0, 11); settle();
        chk("pred_eq_target", int'(target), 11);
        chk("pred_eq_bank10", int'(dut.bank[10]), 11);
        op(0, 1, 0, 1, 0, 1, 0, 0, 11, 0, 12); settle();
        chk("pred_lt_target", int'(target), 11);
        chk("pred_lt_bank11", int'(dut.bank[11]), 0);
        op(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2); settle();
        chk("rst_st_eq", int'(dut.eq_flag), 0);
        chk("rst_st_lt", int'(dut.lt_flag), 0);

        for (int n = 0; n < 400; n++)
            op($urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 4) == 0, ($urandom % 4) == 0,
               ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
               $urandom % 32, $urandom % 32, $urandom % 32);
        imm(13, 17);
        settle();

        @(negedge clk);
        wb = 1; imm_wb = 1; mem_wb = 0; eq_in = 0; lt_in = 0; reset_st = 0; set_st = 0;
        dest = 5'd13; source2 = 5'd21;
        #2 reset = 1;
        #1;
        chk("async_target", int'(target), 0);
        chk("async_bank13", int'(dut.bank[13]), 0);
        chk("async_mem3", int'(dut.mem[3]), 3);
        settle();
        chk("held_target", int'(target), 0);
        chk("held_bank13", int'(dut.bank[13]), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        imm(13, 21);
        op(1, 1, 0, 0, 0, 0, 0, 0, 14, 13, 13); settle();
        chk("post_rst_bank13", int'(dut.bank[13]), 21);
        chk("post_rst_add", int'(target), 10);

        for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
        #3;
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
